// File: rtl/ysyx_23060303_ctrl_pkg.sv
// rtl/ysyx_23060303_ctrl_pkg.sv - state encoding and constants shared by the control FSM
package ysyx_23060303_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM_REQ    = 3'd3,
        ST_MEM_WAIT   = 3'd4,
        ST_WB         = 3'd5,
        ST_HALT       = 3'd6
    } ctrl_state_e;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_ILLEGAL = 2'b10;
    localparam logic [1:0] HALT_TIMEOUT = 2'b11;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ysyx_23060303_wait_timer.sv
// rtl/ysyx_23060303_wait_timer.sv - counts consecutive stalled cycles in a bus-wait state
module ysyx_23060303_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // High during the TIMEOUT-th stalled cycle of the current state
    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/ysyx_23060303_cpu_ctrl.sv
// rtl/ysyx_23060303_cpu_ctrl.sv - multi-cycle instruction sequencer for the RV32E core
module ysyx_23060303_cpu_ctrl
    import ysyx_23060303_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_ifu_req_valid,
    input  logic                 i_ifu_req_ready,
    input  logic                 i_ifu_resp_valid,
    output logic                 o_ifu_resp_ready,
    input  logic [31:0]          i_ifu_inst,
    output logic [31:0]          o_inst_q,
    input  logic                 i_dec_rd_en,
    input  logic                 i_dec_is_load,
    input  logic                 i_dec_is_store,
    input  logic                 i_dec_is_ebreak,
    input  logic                 i_dec_illegal,
    output logic                 o_lsu_req_valid,
    input  logic                 i_lsu_req_ready,
    input  logic                 i_lsu_resp_valid,
    output logic                 o_rf_wen,
    output logic                 o_pc_wen,
    output logic                 o_halt,
    output logic [1:0]           o_halt_code,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt,
    output logic [CNT_WIDTH-1:0] o_instret
);

    ctrl_state_e          r_state;
    ctrl_state_e          w_next;
    logic [31:0]          r_inst;
    logic [1:0]           r_halt_code;
    logic [1:0]           w_halt_code_next;
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instret;
    logic                 w_wait_state;
    logic                 w_exit;
    logic                 w_expire;

    always_comb begin
        w_next           = r_state;
        w_halt_code_next = r_halt_code;
        w_wait_state     = 1'b0;
        w_exit           = 1'b0;
        case (r_state)
            ST_FETCH_REQ: begin
                w_wait_state = 1'b1;
                w_exit       = i_ifu_req_ready;
                if (w_exit) w_next = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                w_wait_state = 1'b1;
                w_exit       = i_ifu_resp_valid;
                if (w_exit) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (i_dec_is_ebreak) begin
                    w_next           = ST_HALT;
                    w_halt_code_next = HALT_EBREAK;
                end else if (i_dec_illegal) begin
                    w_next           = ST_HALT;
                    w_halt_code_next = HALT_ILLEGAL;
                end else if (i_dec_is_load || i_dec_is_store) begin
                    w_next = ST_MEM_REQ;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM_REQ: begin
                w_wait_state = 1'b1;
                w_exit       = i_lsu_req_ready;
                if (w_exit) w_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                w_wait_state = 1'b1;
                w_exit       = i_lsu_resp_valid;
                if (w_exit) w_next = ST_WB;
            end
            ST_WB:   w_next = ST_FETCH_REQ;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_FETCH_REQ;
        endcase
        // A handshake completing on the last allowed cycle still wins over the timeout
        if (w_wait_state && !w_exit && w_expire) begin
            w_next           = ST_HALT;
            w_halt_code_next = HALT_TIMEOUT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_FETCH_REQ;
            r_inst      <= '0;
            r_halt_code <= HALT_NONE;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_state     <= w_next;
            r_halt_code <= w_halt_code_next;
            if (r_state == ST_FETCH_WAIT && i_ifu_resp_valid) r_inst <= i_ifu_inst;
            if (r_state != ST_HALT) r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            if (r_state == ST_WB) r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    ysyx_23060303_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_next != r_state),
        .i_inc    (w_wait_state && !w_exit),
        .o_expire (w_expire)
    );

    assign o_ifu_req_valid  = !i_rst && (r_state == ST_FETCH_REQ);
    assign o_ifu_resp_ready = !i_rst && (r_state == ST_FETCH_WAIT);
    assign o_lsu_req_valid  = !i_rst && (r_state == ST_MEM_REQ);
    assign o_pc_wen         = !i_rst && (r_state == ST_WB);
    assign o_rf_wen         = !i_rst && (r_state == ST_WB) && i_dec_rd_en && !i_dec_is_store;
    assign o_halt           = (r_state == ST_HALT);
    assign o_halt_code      = r_halt_code;
    assign o_inst_q         = r_inst;
    assign o_cycle_cnt      = r_cycle_cnt;
    assign o_instret        = r_instret;

endmodule

// File: tb/tb_ysyx_23060303_cpu_ctrl.sv
// tb/tb_ysyx_23060303_cpu_ctrl.sv - randomized scoreboard bench for the cpu control FSM
module tb_ysyx_23060303_cpu_ctrl;
    import ysyx_23060303_ctrl_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_ifu_req_valid, i_ifu_req_ready, i_ifu_resp_valid, o_ifu_resp_ready;
    logic [31:0] i_ifu_inst, o_inst_q;
    logic        i_dec_rd_en, i_dec_is_load, i_dec_is_store, i_dec_is_ebreak, i_dec_illegal;
    logic        o_lsu_req_valid, i_lsu_req_ready, i_lsu_resp_valid;
    logic        o_rf_wen, o_pc_wen, o_halt;
    logic [1:0]  o_halt_code;
    logic [63:0] o_cycle_cnt, o_instret;

    ysyx_23060303_cpu_ctrl #(.CNT_WIDTH(64), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_ifu_req_valid(o_ifu_req_valid), .i_ifu_req_ready(i_ifu_req_ready),
        .i_ifu_resp_valid(i_ifu_resp_valid), .o_ifu_resp_ready(o_ifu_resp_ready),
        .i_ifu_inst(i_ifu_inst), .o_inst_q(o_inst_q),
        .i_dec_rd_en(i_dec_rd_en), .i_dec_is_load(i_dec_is_load), .i_dec_is_store(i_dec_is_store),
        .i_dec_is_ebreak(i_dec_is_ebreak), .i_dec_illegal(i_dec_illegal),
        .o_lsu_req_valid(o_lsu_req_valid), .i_lsu_req_ready(i_lsu_req_ready),
        .i_lsu_resp_valid(i_lsu_resp_valid),
        .o_rf_wen(o_rf_wen), .o_pc_wen(o_pc_wen), .o_halt(o_halt), .o_halt_code(o_halt_code),
        .o_cycle_cnt(o_cycle_cnt), .o_instret(o_instret)
    );

    initial forever #5 clk = ~clk;

    // IDU stand-in: {rd_en, load, store, ebreak, illegal}
    function automatic logic [4:0] idu(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (w == INST_EBREAK) return 5'b00010;
        case (op)
            7'b0000011: return 5'b11000;
            7'b0100011: return 5'b00100;
            7'b0010011, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 5'b10000;
            7'b1100011: return 5'b00000;
            default:    return 5'b00001;
        endcase
    endfunction
    assign {i_dec_rd_en, i_dec_is_load, i_dec_is_store, i_dec_is_ebreak, i_dec_illegal} = idu(o_inst_q);

    // addi, add, lui, beq, lw, sw
    localparam logic [31:0] PROG_INST [6] = '{32'h00500093, 32'h002081b3, 32'h123452b7,
                                              32'h00208463, 32'h0000a103, 32'h0020a023};
    localparam bit PROG_MEM [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit PROG_RF  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    typedef struct { logic rf; logic [31:0] inst; longint unsigned cyc; longint unsigned ret; } retire_t;
    typedef struct { logic [1:0] code; longint unsigned cyc; longint unsigned ret; } halt_t;

    retire_t          rq[$];
    halt_t            hq[$];
    longint unsigned  m_base = 0;   // cycle_cnt at start of the next instruction
    longint unsigned  m_ret  = 0;
    bit               end_req = 1'b0;
    int               errors = 0;
    int               checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ifu_req_ready = 1'b0; i_ifu_resp_valid = 1'b0; i_ifu_inst = '0;
        i_lsu_req_ready = 1'b0; i_lsu_resp_valid = 1'b0;
    endtask

    task automatic noise_ifu();
        i_ifu_req_ready = 1'($urandom); i_ifu_resp_valid = 1'($urandom); i_ifu_inst = $urandom;
    endtask

    task automatic noise_lsu();
        i_lsu_req_ready = 1'($urandom); i_lsu_resp_valid = 1'($urandom);
    endtask

    function automatic int rw();
        return ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 4));
    endfunction

    task automatic fetch_req(input int fq);
        i_ifu_req_ready = 1'b0;
        repeat (fq) begin noise_lsu(); i_ifu_resp_valid = 1'($urandom); i_ifu_inst = $urandom; step(); end
        i_ifu_req_ready = 1'b1; step(); i_ifu_req_ready = 1'b0;
    endtask

    task automatic fetch_resp(input logic [31:0] inst, input int fp);
        i_ifu_resp_valid = 1'b0;
        repeat (fp) begin noise_lsu(); i_ifu_inst = $urandom; step(); end
        i_ifu_inst = inst; i_ifu_resp_valid = 1'b1; step(); i_ifu_resp_valid = 1'b0;
    endtask

    task automatic exec_step();
        noise_ifu(); noise_lsu(); step();
    endtask

    task automatic mem_req(input int mq);
        i_lsu_req_ready = 1'b0;
        repeat (mq) begin noise_ifu(); i_lsu_resp_valid = 1'($urandom); step(); end
        i_lsu_req_ready = 1'b1; step(); i_lsu_req_ready = 1'b0;
    endtask

    task automatic mem_resp(input int mp);
        i_lsu_resp_valid = 1'b0;
        repeat (mp) begin noise_ifu(); i_lsu_req_ready = 1'($urandom); step(); end
        i_lsu_resp_valid = 1'b1; step(); i_lsu_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs(); i_rst = 1'b1; step(); i_rst = 1'b0;
        m_base = 0; m_ret = 0;
    endtask

    task automatic run_instr(input int idx, input int fq, input int fp, input int mq, input int mp);
        retire_t r;
        longint unsigned len;
        len = longint'(fq + fp + 4) + (PROG_MEM[idx] ? longint'(mq + mp + 2) : 64'd0);
        r.rf = PROG_RF[idx]; r.inst = PROG_INST[idx]; r.cyc = m_base + len - 64'd1; r.ret = m_ret;
        rq.push_back(r);
        m_base += len; m_ret += 64'd1;
        fetch_req(fq); fetch_resp(PROG_INST[idx], fp); exec_step();
        if (PROG_MEM[idx]) begin mem_req(mq); mem_resp(mp); end
        noise_ifu(); noise_lsu(); step();
    endtask

    task automatic push_halt(input logic [1:0] code, input longint unsigned cyc);
        halt_t h;
        h.code = code; h.cyc = cyc; h.ret = m_ret;
        hq.push_back(h);
    endtask

    // kinds: 0 ebreak, 1 illegal, 2..5 timeout in each wait state, 6 reset during MEM_WAIT
    task automatic terminate(input int kind, input int fq, input int fp, input int mq, input int hold);
        logic [31:0] mi, ill;
        longint unsigned pre;
        mi  = ($urandom_range(0, 1) == 1) ? PROG_INST[4] : PROG_INST[5];
        ill = ($urandom_range(0, 1) == 1) ? 32'hffffffff : 32'h00000073;
        pre = m_base + longint'(fq + fp + 3);
        case (kind)
            0, 1: begin
                push_halt((kind == 0) ? HALT_EBREAK : HALT_ILLEGAL, pre);
                fetch_req(fq); fetch_resp((kind == 0) ? INST_EBREAK : ill, fp); exec_step();
            end
            2: begin
                push_halt(HALT_TIMEOUT, m_base + longint'(TMO));
                i_ifu_req_ready = 1'b0;
                repeat (TMO) begin noise_lsu(); step(); end
            end
            3: begin
                push_halt(HALT_TIMEOUT, m_base + longint'(fq + 1 + TMO));
                fetch_req(fq); i_ifu_resp_valid = 1'b0;
                repeat (TMO) begin noise_lsu(); i_ifu_inst = $urandom; step(); end
            end
            4: begin
                push_halt(HALT_TIMEOUT, pre + longint'(TMO));
                fetch_req(fq); fetch_resp(mi, fp); exec_step(); i_lsu_req_ready = 1'b0;
                repeat (TMO) begin noise_ifu(); i_lsu_resp_valid = 1'($urandom); step(); end
            end
            5: begin
                push_halt(HALT_TIMEOUT, pre + longint'(mq + 1 + TMO));
                fetch_req(fq); fetch_resp(mi, fp); exec_step(); mem_req(mq); i_lsu_resp_valid = 1'b0;
                repeat (TMO) begin noise_ifu(); i_lsu_req_ready = 1'($urandom); step(); end
            end
            default: begin
                fetch_req(fq); fetch_resp(PROG_INST[4], fp); exec_step(); mem_req(mq);
                i_lsu_resp_valid = 1'b0;
                repeat (hold % 4) step();
                i_rst = 1'b1; i_lsu_resp_valid = 1'b1; step();
                clear_inputs(); i_rst = 1'b0; m_base = 0; m_ret = 0;
            end
        endcase
        if (kind < 6) repeat (hold) begin noise_ifu(); noise_lsu(); step(); end
    endtask

    initial begin
        clear_inputs(); i_rst = 1'b1; step();
        do_reset(); run_instr(0, 0, 0, 0, 0); run_instr(0, 0, 0, 0, 0);
        do_reset(); run_instr(4, 0, 0, 3, 1);
        do_reset(); run_instr(5, 0, 0, 0, 0);
        do_reset(); terminate(0, 0, 0, 0, 20);
        do_reset(); terminate(2, 0, 0, 0, 5);
        do_reset(); run_instr(0, TMO - 1, TMO - 1, 0, 0); run_instr(4, 0, 0, TMO - 1, TMO - 1);
        run_instr(5, TMO - 1, 0, 0, TMO - 1);
        do_reset(); terminate(6, 0, 0, 0, 1); run_instr(0, 0, 0, 0, 0);
        for (int e = 0; e < 14; e++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) run_instr(int'($urandom_range(0, 5)), rw(), rw(), rw(), rw());
            terminate(int'($urandom_range(0, 6)), rw(), rw(), rw(), int'($urandom_range(3, 20)));
        end
        end_req = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit      prev_rst;
        bit      halt_seen;
        halt_t   cur;
        retire_t r;
        prev_rst  = 1'b0;
        halt_seen = 1'b0;
        cur.code = '0; cur.cyc = 0; cur.ret = 0;
        forever begin
            @(negedge clk);
            if (end_req) begin
                chk("pending_retire", 64'(rq.size()), 64'd0);
                chk("pending_halt", 64'(hq.size()), 64'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else if (i_rst) begin
                chk("rst_outputs_low", 64'({o_ifu_req_valid, o_ifu_resp_ready, o_lsu_req_valid,
                                            o_rf_wen, o_pc_wen}), 64'd0);
                halt_seen = 1'b0;
                prev_rst  = 1'b1;
            end else begin
                if (prev_rst) begin
                    chk("post_rst_inst_q", 64'(o_inst_q), 64'd0);
                    chk("post_rst_cycle_cnt", o_cycle_cnt, 64'd0);
                    chk("post_rst_instret", o_instret, 64'd0);
                    chk("post_rst_fetch_req", 64'({o_ifu_req_valid, o_halt, o_halt_code}), 64'b1000);
                end
                prev_rst = 1'b0;
                if (o_halt) begin
                    if (!halt_seen) begin
                        halt_seen = 1'b1;
                        chk("halt_expected", 64'(hq.size() != 0), 64'd1);
                        if (hq.size() != 0) begin
                            cur = hq.pop_front();
                            chk("halt_code", 64'(o_halt_code), 64'(cur.code));
                        end
                    end
                    chk("halt_cycle_cnt", o_cycle_cnt, cur.cyc);
                    chk("halt_instret", o_instret, cur.ret);
                    chk("halt_quiet", 64'({o_ifu_req_valid, o_ifu_resp_ready, o_lsu_req_valid,
                                           o_rf_wen, o_pc_wen}), 64'd0);
                end else begin
                    chk("halt_code_running", 64'(o_halt_code), 64'd0);
                    if (o_pc_wen) begin
                        chk("retire_expected", 64'(rq.size() != 0), 64'd1);
                        if (rq.size() != 0) begin
                            r = rq.pop_front();
                            chk("wb_rf_wen", 64'(o_rf_wen), 64'(r.rf));
                            chk("wb_inst_q", 64'(o_inst_q), 64'(r.inst));
                            chk("wb_cycle_cnt", o_cycle_cnt, r.cyc);
                            chk("wb_instret", o_instret, r.ret);
                        end
                    end else begin
                        chk("rf_wen_outside_wb", 64'(o_rf_wen), 64'd0);
                    end
                end
            end
        end
    end

endmodule
